lzc_norm_sched: RTL and testbench

- Shares one leading-zero counter, lzc_d, between NREQ requesters, e.g. the rayDirX/rayDirY reciprocal paths.
- Per request: counts leading zeroes and produces the left-normalised operand, which feeds the reciprocal/normalisation datapath.
- Round-robin arbitration, valid/ready handshakes on both sides.
- One request in flight at a time; the result is registered and held until consumed.

---
 rtl/lzc_sched_pkg.sv | 16 +
 rtl/lzc_d.sv | 24 ++
 rtl/rr_grant.sv | 42 ++++
 rtl/lzc_norm_sched.sv | 167 ++++++++++++++++
 tb/tb_lzc_norm_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lzc_sched_pkg.sv
// Shared types and constants for the leading-zero normaliser scheduler.
//   state_t    : scheduler FSM states
//   LZC_CNT_W  : fixed output width of the lzc_d leading-zero counter
//   MAX_NREQ   : largest supported requester count
package lzc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int LZC_CNT_W = 7;
   localparam int MAX_NREQ  = 8;

endpackage

// File: rtl/lzc_d.sv
// Leading-zero counter, combinational.
//   din : operand, WIDTH bits (power of 2, at most 64)
//   cnt : number of leading zeroes, 0..WIDTH (WIDTH for an all-zero operand)
module lzc_d #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] din,
   output logic [6:0]       cnt
);

   logic found;

   always_comb begin
      cnt   = 7'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            found = 1'b1;
            cnt   = 7'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant selection, purely combinational.
//   req         : per-requester request vector
//   last_grant  : index granted last time (owned by the caller)
//   enable      : when low, no grant is produced
//   grant       : one-hot grant (or zero)
//   grant_idx   : index of the granted requester
//   grant_valid : a grant was produced
module rr_grant #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_valid
);

   int unsigned    cand;
   logic [IDW-1:0] cand_idx;

   // Search starts one past the last winner and wraps, so the last winner
   // is considered only after every other requester.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand     = (32'(last_grant) + 32'(i)) % 32'(NREQ);
         cand_idx = IDW'(cand);
         if (enable && !grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/lzc_norm_sched.sv
// Shares one leading-zero counter between NREQ requesters. Each accepted
// operand is counted and left-normalised; the result is held until consumed.
//   clk, reset : clock (rising edge), async active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept, one-hot or zero (combinational)
//   req_data   : operands, requester k at [k*WIDTH +: WIDTH]
//   resp_valid : result valid
//   resp_ready : consumer accepts the result
//   resp_id    : requester owning the result
//   resp_cnt   : leading-zero count, 0..WIDTH
//   resp_norm  : operand << resp_cnt (0 for a zero operand)
//   resp_zero  : operand was zero
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | operand register drives lzc_d
// HOLD  | resp_valid high, waiting for resp_ready
module lzc_norm_sched
   import lzc_sched_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [IDW-1:0]        resp_id,
   output logic [LZC_CNT_W-1:0]  resp_cnt,
   output logic [WIDTH-1:0]      resp_norm,
   output logic                  resp_zero
);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     op_q, op_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [IDW-1:0]       last_grant_q, last_grant_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [IDW-1:0]       resp_id_q, resp_id_d;
   logic [LZC_CNT_W-1:0] resp_cnt_q, resp_cnt_d;
   logic [WIDTH-1:0]     resp_norm_q, resp_norm_d;
   logic                 resp_zero_q, resp_zero_d;

   logic                 accept_en;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       grant_idx;
   logic                 grant_valid;
   logic [LZC_CNT_W-1:0] lzc_cnt;
   logic [WIDTH-1:0]     grant_data;

   // A new request may enter only when the result slot is free or is
   // being emptied this cycle.
   assign accept_en = (state_q == IDLE) || ((state_q == HOLD) && resp_ready);

   rr_grant #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_grant (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .enable      (accept_en),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   lzc_d #(
      .WIDTH (WIDTH)
   ) u_lzc_d (
      .din (op_q),
      .cnt (lzc_cnt)
   );

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            grant_data = req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_cnt_d   = resp_cnt_q;
      resp_norm_d  = resp_norm_q;
      resp_zero_d  = resp_zero_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               op_d         = grant_data;
               id_d         = grant_idx;
               last_grant_d = grant_idx;
               state_d      = CALC;
            end
         end
         CALC: begin
            // A shift by WIDTH yields zero, which is the required result
            // for a zero operand.
            resp_cnt_d   = lzc_cnt;
            resp_norm_d  = op_q << lzc_cnt;
            resp_zero_d  = (op_q == '0);
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
            state_d      = HOLD;
         end
         HOLD: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               if (grant_valid) begin
                  op_d         = grant_data;
                  id_d         = grant_idx;
                  last_grant_d = grant_idx;
                  state_d      = CALC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= '0;
         id_q         <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_cnt_q   <= '0;
         resp_norm_q  <= '0;
         resp_zero_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_cnt_q   <= resp_cnt_d;
         resp_norm_q  <= resp_norm_d;
         resp_zero_q  <= resp_zero_d;
      end
   end

   assign req_ready  = grant;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_cnt   = resp_cnt_q;
   assign resp_norm  = resp_norm_q;
   assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_lzc_norm_sched.sv
module tb_lzc_norm_sched;

   localparam int WIDTH = 32;
   localparam int NREQ  = 2;
   localparam int IDW   = 1;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [6:0]            resp_cnt;
   logic [WIDTH-1:0]      resp_norm;
   logic                  resp_zero;

   lzc_norm_sched #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_cnt   (resp_cnt),
      .resp_norm  (resp_norm),
      .resp_zero  (resp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: 0=idle, 1=operand captured, 2=result on offer.
   int          m_st;
   int          m_last;
   logic [31:0] m_op;
   int          m_id;
   int          m_acc;
   logic        e_valid;
   int          e_id;
   int          e_cnt;
   logic [31:0] e_norm;
   logic        e_zero;
   logic [1:0]  obs_ready;

   function automatic int ref_cnt(input logic [31:0] x);
      longint v;
      int     bits;
      v    = longint'(x);
      bits = 0;
      while (v > 0) begin
         v = v / 2;
         bits++;
      end
      return WIDTH - bits;
   endfunction

   function automatic logic [31:0] ref_norm(input logic [31:0] x);
      logic [63:0] prod;
      prod = 64'(x) * (64'd1 << ref_cnt(x));
      return prod[31:0];
   endfunction

   task automatic model_reset();
      m_st    = 0;
      m_last  = NREQ - 1;
      m_op    = '0;
      m_id    = 0;
      m_acc   = -1;
      e_valid = 1'b0;
      e_id    = 0;
      e_cnt   = 0;
      e_norm  = '0;
      e_zero  = 1'b0;
   endtask

   task automatic cycle(input logic [1:0] vld, input logic [31:0] d0,
                        input logic [31:0] d1, input logic rr);
      logic        en;
      int          k;
      int          c;
      logic [31:0] dat [2];
      @(negedge clk);
      req_valid  = vld;
      req_data   = {d1, d0};
      resp_ready = rr;
      dat[0]     = d0;
      dat[1]     = d1;
      #1;
      en = (m_st == 0) || (m_st == 2 && rr);
      k  = -1;
      if (en) begin
         for (int j = 1; j <= NREQ; j++) begin
            c = (m_last + j) % NREQ;
            if (vld[c] && k < 0) k = c;
         end
      end
      obs_ready = req_ready;
      chk("req_ready", 64'(req_ready), (k >= 0) ? (64'd1 << k) : 64'd0);
      chk("resp_valid", 64'(resp_valid), 64'(e_valid));
      chk("resp_id", 64'(resp_id), 64'(e_id));
      chk("resp_cnt", 64'(resp_cnt), 64'(e_cnt));
      chk("resp_norm", 64'(resp_norm), 64'(e_norm));
      chk("resp_zero", 64'(resp_zero), 64'(e_zero));
      m_acc = k;
      if (m_st == 1) begin
         e_cnt   = ref_cnt(m_op);
         e_norm  = ref_norm(m_op);
         e_zero  = (m_op == 0);
         e_id    = m_id;
         e_valid = 1'b1;
         m_st    = 2;
      end else if (en) begin
         e_valid = 1'b0;
         if (k >= 0) begin
            m_op   = dat[k];
            m_id   = k;
            m_last = k;
            m_st   = 1;
         end else begin
            m_st = 0;
         end
      end
      @(posedge clk);
   endtask

   task automatic run_single(input int who, input logic [31:0] d, input int x_cnt,
                             input logic [31:0] x_norm, input logic x_zero);
      cycle(who == 1 ? 2'b10 : 2'b01, d, d, 1'b1);
      chk("single_accept", 64'(obs_ready), who == 1 ? 64'd2 : 64'd1);
      cycle(2'b00, 32'h0, 32'h0, 1'b0);
      #1;
      chk("single_valid", 64'(resp_valid), 64'd1);
      chk("single_cnt", 64'(resp_cnt), 64'(x_cnt));
      chk("single_norm", 64'(resp_norm), 64'(x_norm));
      chk("single_zero", 64'(resp_zero), 64'(x_zero));
      chk("single_id", 64'(resp_id), 64'(who));
      cycle(2'b00, 32'h0, 32'h0, 1'b1);
   endtask

   int          order_q [$];
   logic        pend [2];
   logic [31:0] pdata [2];

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      resp_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_cnt", 64'(resp_cnt), 64'd0);
      chk("rst_norm", 64'(resp_norm), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);

      run_single(0, 32'h0000_1234, 19, 32'h91A0_0000, 1'b0);
      run_single(0, 32'h8000_0000, 0, 32'h8000_0000, 1'b0);
      run_single(0, 32'h0000_0001, 31, 32'h8000_0000, 1'b0);
      run_single(0, 32'h0000_0000, 32, 32'h0000_0000, 1'b1);
      run_single(1, 32'h00FF_0000, 8, 32'hFF00_0000, 1'b0);

      // Fairness: both requesters held high.
      for (int i = 0; i < 12; i++) begin
         cycle(2'b11, 32'h0000_0F00 + 32'(i), 32'h00FF_0000, 1'b1);
         if (obs_ready != 2'b00) order_q.push_back(obs_ready == 2'b10 ? 1 : 0);
      end
      chk("fair_count", 64'(order_q.size()), 64'd6);
      for (int i = 0; i < order_q.size(); i++) chk("fair_order", 64'(order_q[i]), 64'(i % 2));
      repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b1);

      // Backpressure with requester 1 waiting.
      cycle(2'b01, 32'h0003_C000, 32'h0, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b0);
      repeat (5) cycle(2'b10, 32'h0, 32'h1234_5678, 1'b0);
      cycle(2'b10, 32'h0, 32'h1234_5678, 1'b1);
      chk("bp_accept", 64'(obs_ready), 64'd2);

      // Asynchronous reset while in CALC.
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(resp_valid), 64'd0);
      chk("arst_cnt", 64'(resp_cnt), 64'd0);
      chk("arst_norm", 64'(resp_norm), 64'd0);
      chk("arst_id", 64'(resp_id), 64'd0);
      chk("arst_zero", 64'(resp_zero), 64'd0);
      model_reset();
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      cycle(2'b11, 32'h0000_0100, 32'h0000_0200, 1'b1);
      chk("arst_first_grant", 64'(obs_ready), 64'd1);
      repeat (3) cycle(2'b00, 32'h0, 32'h0, 1'b1);

      // Randomised traffic with protocol-legal requesters.
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      pdata[0] = '0;
      pdata[1] = '0;
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
               if ($urandom_range(0, 2) == 0) begin
                  pend[r]  = 1'b1;
                  pdata[r] = $urandom >> $urandom_range(0, 32);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               pend[r] = 1'b0;
            end
         end
         cycle({pend[1], pend[0]}, pdata[0], pdata[1], $urandom_range(0, 3) != 0);
         if (m_acc >= 0) pend[m_acc] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
